// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, waits for a stable lock with timeout/retry,
// then releases downstream domain resets in staggered index order.
module pll_lock_supervisor #(
  parameter int unsigned NCHAN       = 4,
  parameter int unsigned PLLRST_LEN  = 32,
  parameter int unsigned TIMEOUT     = 65536,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned STAGGER     = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             clear_count,
  output logic             pll_rst,
  output logic [NCHAN-1:0] rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int unsigned MAX_A = (PLLRST_LEN > TIMEOUT) ? PLLRST_LEN : TIMEOUT;
  localparam int unsigned MAX_B = (LOCK_STABLE > STAGGER) ? LOCK_STABLE : STAGGER;
  localparam int unsigned TMAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TMR_W = $clog2(TMAX);

  localparam logic [TMR_W-1:0] PLLRST_LAST  = TMR_W'(PLLRST_LEN - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE - 1);
  localparam logic [TMR_W-1:0] STAGGER_LAST = TMR_W'(STAGGER - 1);

  typedef enum logic [2:0] {
    PLLRST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             sync1;
  logic             lock_s;
  logic             loss_inc_c;
  logic             retry_inc_c;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // Counter event strobes, shared by the FSM and the saturating counters
  always_comb begin
    loss_inc_c  = 1'b0;
    retry_inc_c = 1'b0;
    if ((state == RELEASE || state == RUN) && !lock_s) loss_inc_c = 1'b1;
    if (state == WAIT_LOCK && !lock_s && timer == TIMEOUT_LAST) retry_inc_c = 1'b1;
  end

  // A clear coincident with an event leaves the count at one
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic clr);
    if (clr) return inc ? CNT_W'(1) : '0;
    if (inc && c != '1) return c + CNT_W'(1);
    return c;
  endfunction

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= PLLRST;
      timer       <= '0;
      pll_rst     <= 1'b1;
      rst_out     <= '1;
      ready       <= 1'b0;
      loss_count  <= '0;
      retry_count <= '0;
    end else begin
      loss_count  <= cnt_next(loss_count, loss_inc_c, clear_count);
      retry_count <= cnt_next(retry_count, retry_inc_c, clear_count);
      case (state)
        PLLRST: begin
          if (timer == PLLRST_LAST) begin
            pll_rst <= 1'b0;
            timer   <= '0;
            state   <= WAIT_LOCK;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            timer <= '0;
            state <= STABLE;
          end else if (retry_inc_c) begin
            pll_rst <= 1'b1;
            timer   <= '0;
            state   <= PLLRST;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            timer <= '0;
            state <= WAIT_LOCK;
          end else if (timer == STABLE_LAST) begin
            rst_out <= {NCHAN{1'b1}} << 1;
            timer   <= '0;
            state   <= RELEASE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RELEASE, RUN: begin
          if (loss_inc_c) begin
            rst_out <= '1;
            ready   <= 1'b0;
            timer   <= '0;
            state   <= WAIT_LOCK;
          end else if (state == RELEASE) begin
            // Left shift keeps the released bits contiguous from index 0
            if (rst_out == '0) begin
              ready <= 1'b1;
              state <= RUN;
            end else if (timer == STAGGER_LAST) begin
              rst_out <= rst_out << 1;
              timer   <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end
        default: state <= PLLRST;
      endcase
    end
  end

endmodule
